// File: rtl/yj_basic_cdc_word_rx.sv
// Receive side of a toggle-request word crossing: captures the held source word, presents it valid/ready, returns an ack toggle.
// Optional feature macro YJ_CDC_RX_EARLY_ACK_EN: ack on capture instead of on consumer handshake.
module yj_basic_cdc_word_rx #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_tgl_sync,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          ack_tgl,
  output logic          err_ovr,
  output logic [CW-1:0] rx_cnt
);

`ifdef YJ_CDC_RX_EARLY_ACK_EN
  localparam bit EarlyAck = 1'b1;
`else
  localparam bit EarlyAck = 1'b0;
`endif

  typedef enum logic [1:0] {INIT, IDLE, HOLD} state_t;

  state_t state;
  logic   req_d;
  logic   req_edge;
  logic   handshake;

  // INIT suppresses the edge so a request level left high across reset is not taken as a new word.
  assign req_edge  = (state != INIT) && (req_tgl_sync ^ req_d);
  assign handshake = dout_valid & dout_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= INIT;
      req_d      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ack_tgl    <= 1'b0;
      err_ovr    <= 1'b0;
      rx_cnt     <= '0;
    end else begin
      req_d <= req_tgl_sync;
      unique case (state)
        INIT: state <= IDLE;
        IDLE: begin
          if (req_edge) begin
            dout       <= data_in;
            rx_cnt     <= rx_cnt + 1'b1;
            dout_valid <= 1'b1;
            state      <= HOLD;
            if (EarlyAck) ack_tgl <= ~ack_tgl;
          end
        end
        HOLD: begin
          // Back-to-back capture owes exactly one ack in either mode: for the new word early, for the taken word late.
          if (handshake && req_edge) begin
            dout    <= data_in;
            rx_cnt  <= rx_cnt + 1'b1;
            ack_tgl <= ~ack_tgl;
          end else if (handshake) begin
            dout_valid <= 1'b0;
            state      <= IDLE;
            if (!EarlyAck) ack_tgl <= ~ack_tgl;
          end else if (req_edge) begin
            err_ovr <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/yj_basic_cdc_word_rx.md
# yj_basic_cdc_word_rx

Receive side of a toggle-request word crossing. It sits directly downstream of the two-level synchronizer and consumes the synchronized request toggle. It captures the source-held data bus into a local register and presents it on a valid/ready interface. It then returns an acknowledge toggle, which the source domain synchronizes back. Captured words are counted for debug.

## Interface
- DW, 32: data word width.
- CW, 8: capture counter width.
- CLK  input  1  receive-domain clock; all state on posedge.
- RST  input  1  asynchronous, active-high reset.
- req_tgl_sync  input  1  request toggle, already passed through the two-level synchronizer; each level change means one new word.
- data_in  input  DW  source-domain data bus; the source holds it stable from before its request toggle until the matching ack toggle is seen.
- dout  output  DW  captured word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle when dout_valid is 1.
- ack_tgl  output  1  acknowledge toggle back to the source domain; registered.
- err_ovr  output  1  sticky overrun flag.
- rx_cnt  output  CW  number of words captured, modulo 2^CW.

## Operation
- One clock; reset is asynchronous and active-high (RST). Every output and internal register is cleared on RST: dout=0, dout_valid=0, ack_tgl=0, err_ovr=0, rx_cnt=0, req_d=0, state=INIT.
- req_d is a register tracking req_tgl_sync. edge = req_tgl_sync ^ req_d, and is computed only outside INIT.
- The state machine has three states:
  - INIT: the first cycle after reset release. Loads req_d from req_tgl_sync and captures nothing, so no spurious edge is taken from a level left high. Next state is IDLE.
  - IDLE: dout_valid=0. On edge, load dout from data_in, increment rx_cnt, and go to HOLD.
  - HOLD: dout_valid=1, and dout stays stable until handshake (dout_valid & dout_ready).
    - handshake without edge: go to IDLE.
    - handshake with edge: capture the new word, increment rx_cnt, stay in HOLD (back-to-back).
    - edge without handshake: overrun. Set err_ovr=1, drop the word, leave dout unchanged, leave rx_cnt unchanged, send no ack for the dropped word.
- req_d updates every cycle outside reset, so each edge is seen exactly once.
- Ack timing depends on YJ_CDC_RX_EARLY_ACK_EN; see Configuration.
- rx_cnt wraps from 2^CW-1 to 0 with no flag.
- err_ovr is cleared only by RST.
- An RST assertion mid-transfer discards any held word and returns ack_tgl to 0. Both domains are required to reset together.

## Timing
- Edge visible on req_tgl_sync in cycle N: dout and dout_valid are updated at posedge N+1, using data_in sampled in cycle N.
- Capture latency from the source toggle is 2 synchronizer cycles plus 1 cycle.
- Ack with the macro off: ack_tgl flips at the posedge ending the handshake cycle.
- Ack with the macro on: ack_tgl flips at posedge N+1, together with dout_valid rising.
- Throughput with the macro off is one word per round trip: source toggle, 3 rx cycles, handshake, ack synchronized back.
- dout_ready has no combinational path to any output.

## Configuration
- YJ_CDC_RX_EARLY_ACK_EN undefined (default):
  - ack_tgl toggles only on handshake, so the source cannot send again until the consumer has taken the word.
  - Overrun is impossible under a legal source; err_ovr detects protocol violations only.
- YJ_CDC_RX_EARLY_ACK_EN defined:
  - ack_tgl toggles on each capture, including a back-to-back capture in HOLD, so the source may launch the next word while dout is still pending.
  - A slow consumer then causes overrun, reported through err_ovr.
  - Dropped words are never acked. The source stalls, which is the intended failure signature.

## Test plan
- Reset with req_tgl_sync=1, release -> no capture, dout_valid=0, rx_cnt=0, ack_tgl=0 through 10 cycles.
- data_in=32'hA5A5_1234, toggle req with dout_ready=1 -> dout_valid=1 one cycle after the edge, dout=32'hA5A5_1234, rx_cnt=1. ack_tgl=1 one cycle after the handshake (macro off), or with valid (macro on).
- Hold dout_ready=0 for 20 cycles -> dout stable, dout_valid=1. Ack not toggled (macro off).
- Macro on, dout_ready=0, second toggle with data_in=32'h0000_0002 -> err_ovr=1, dout unchanged, rx_cnt=1, ack_tgl unchanged. Then an edge in the same cycle as a handshake -> new word captured, dout_valid stays 1.
- CW=4, 17 legal transfers -> rx_cnt=1 (wrapped), err_ovr=0.
- Assert RST while in HOLD -> all outputs 0 asynchronously, then INIT on release.
